// File: rtl/delay_ctrl_if.sv
// delay_ctrl_if: sample stream and depth-config handshake bundle for delay_ctrl
interface delay_ctrl_if #(
  parameter int DATA_W = 48,
  parameter int DW     = 6
) ();
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic [DW-1:0]     cfg_depth_i;
  logic              cfg_req_i;
  logic              cfg_ack_o;
  logic              cfg_err_o;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              busy_o;
  modport master (
    output data_i, valid_i, cfg_depth_i, cfg_req_i,
    input  cfg_ack_o, cfg_err_o, data_o, valid_o, busy_o
  );
  modport slave (
    input  data_i, valid_i, cfg_depth_i, cfg_req_i,
    output cfg_ack_o, cfg_err_o, data_o, valid_o, busy_o
  );
endinterface

// File: rtl/delay_ctrl.sv
// delay_ctrl: runtime-programmable sample delay over a RAM ring buffer with FILL/RUN/FLUSH gating
// Optional bypass path enabled by defining DELAY_CTRL_BYPASS_EN.
module delay_ctrl #(
  parameter int DATA_W    = 48,
  parameter int MAX_DEPTH = 32,
  parameter int DEF_DEPTH = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
`ifdef DELAY_CTRL_BYPASS_EN
  input  logic         bypass_i,
`endif
  delay_ctrl_if.slave  bus
);
  localparam int AW = $clog2(MAX_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] MAXD = DW'(MAX_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t            state, state_nx;
  logic [DW-1:0]     depth, fill, new_depth;
  logic [AW-1:0]     wp, rd_idx;
  logic              acc, cfg_acc, clamp, ok, nx_valid, nx_load;
  logic [DATA_W-1:0] rd_data, nx_data;
  logic [DATA_W-1:0] mem [MAX_DEPTH];
  // Decode accepts, clamp the requested depth and pick the outgoing sample.
  // A config accept applies its new depth to a sample accepted in the same cycle.
  always_comb begin
    acc       = bus.valid_i;
    cfg_acc   = bus.cfg_req_i && !bus.cfg_ack_o;
    clamp     = bus.cfg_depth_i > MAXD;
    new_depth = clamp ? MAXD : bus.cfg_depth_i;
    rd_idx    = wp - depth[AW-1:0];
    rd_data   = (cfg_acc || depth == '0) ? bus.data_i : mem[rd_idx];
    ok        = cfg_acc ? new_depth == '0 : fill >= depth;
    state_nx  = cfg_acc ? FLUSH :
                (acc && ok) ? RUN :
                acc ? FILL :
                state == FLUSH ? (depth == '0 ? RUN : FILL) : state;
`ifdef DELAY_CTRL_BYPASS_EN
    nx_valid  = bypass_i ? acc : acc && ok;
    nx_load   = bypass_i || (acc && ok);
    nx_data   = bypass_i ? bus.data_i : rd_data;
`else
    nx_valid  = acc && ok;
    nx_load   = acc && ok;
    nx_data   = rd_data;
`endif
  end
  // Ring storage: written on every accept, never reset.
  always_ff @(posedge clk_i) begin
    if (acc) mem[wp] <= bus.data_i;
  end
  // Control state, fill tracking and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      depth         <= DW'(DEF_DEPTH);
      fill          <= '0;
      wp            <= '0;
      bus.data_o    <= '0;
      bus.valid_o   <= 1'b0;
      bus.cfg_ack_o <= 1'b0;
      bus.cfg_err_o <= 1'b0;
      bus.busy_o    <= 1'b1;
    end else begin
      state         <= state_nx;
      bus.busy_o    <= state_nx != RUN;
      bus.cfg_ack_o <= cfg_acc;
      bus.cfg_err_o <= cfg_acc && clamp;
      bus.valid_o   <= nx_valid;
      if (nx_load) bus.data_o <= nx_data;
      if (acc) wp <= wp + 1'b1;
      if (cfg_acc) begin
        depth <= new_depth;
        fill  <= DW'(acc && new_depth != '0);
      end else if (acc && fill < depth) begin
        fill <= fill + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_delay_ctrl.sv
// tb_delay_ctrl: directed checks of fill gating, reconfiguration, clamping, zero depth, reset and gaps
module tb_delay_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  delay_ctrl_if #(.DATA_W(48), .DW(6)) bus ();
`ifdef DELAY_CTRL_BYPASS_EN
  logic bypass = 1'b0;
`endif
  delay_ctrl #(.DATA_W(48), .MAX_DEPTH(32), .DEF_DEPTH(15)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
`ifdef DELAY_CTRL_BYPASS_EN
    .bypass_i(bypass),
`endif
    .bus   (bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [47:0] d);
    bus.valid_i = v;
    bus.data_i  = d;
  endtask
  task automatic test_reset;
    drive(1'b0, 48'd0);
    bus.cfg_req_i = 1'b0;
    bus.cfg_depth_i = 6'd0;
    @(posedge clk);
    #1;
    tests++;
    if ({bus.valid_o, bus.data_o, bus.cfg_ack_o, bus.cfg_err_o, bus.busy_o} !== {1'b0, 48'd0, 1'b0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset: valid=%0b data=%0h ack=%0b err=%0b busy=%0b, want 0 0 0 0 1",
               bus.valid_o, bus.data_o, bus.cfg_ack_o, bus.cfg_err_o, bus.busy_o);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_fill;
    logic ev, eb;
    logic [47:0] ed;
    for (int k = 1; k <= 40; k++) begin
      drive(1'b1, 48'(k));
      tick;
      ev = k >= 16;
      eb = k < 16;
      ed = k >= 16 ? 48'(k - 15) : 48'd0;
      tests++;
      if ({bus.valid_o, bus.data_o, bus.busy_o} !== {ev, ed, eb}) begin
        fails++;
        $display("FAIL fill k=%0d: valid=%0b data=%0d busy=%0b, want %0b %0d %0b",
                 k, bus.valid_o, bus.data_o, bus.busy_o, ev, ed, eb);
      end
    end
  endtask
  task automatic test_depth_change;
    logic ev, eb;
    logic [47:0] ed;
    drive(1'b1, 48'd41);
    bus.cfg_req_i = 1'b1;
    bus.cfg_depth_i = 6'd4;
    tick;
    tests++;
    if ({bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o} !== {1'b1, 1'b0, 1'b0, 48'd25}) begin
      fails++;
      $display("FAIL depth4 ack: ack=%0b err=%0b valid=%0b data=%0d, want 1 0 0 25",
               bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o);
    end
    bus.cfg_req_i = 1'b0;
    for (int i = 42; i <= 48; i++) begin
      drive(1'b1, 48'(i));
      tick;
      ev = i >= 45;
      eb = i < 45;
      ed = i >= 45 ? 48'(i - 4) : 48'd25;
      tests++;
      if ({bus.cfg_ack_o, bus.valid_o, bus.data_o, bus.busy_o} !== {1'b0, ev, ed, eb}) begin
        fails++;
        $display("FAIL depth4 i=%0d: ack=%0b valid=%0b data=%0d busy=%0b, want 0 %0b %0d %0b",
                 i, bus.cfg_ack_o, bus.valid_o, bus.data_o, bus.busy_o, ev, ed, eb);
      end
    end
  endtask
  task automatic test_clamp;
    logic ev;
    logic [47:0] ed;
    drive(1'b1, 48'd49);
    bus.cfg_req_i = 1'b1;
    bus.cfg_depth_i = 6'd40;
    tick;
    tests++;
    if ({bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o} !== {1'b1, 1'b1, 1'b0, 48'd44}) begin
      fails++;
      $display("FAIL clamp ack: ack=%0b err=%0b valid=%0b data=%0d, want 1 1 0 44",
               bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o);
    end
    bus.cfg_req_i = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      drive(1'b1, 48'(49 + i));
      tick;
      ev = i >= 31;
      ed = i >= 31 ? 48'(18 + i) : 48'd44;
      tests++;
      if ({bus.cfg_err_o, bus.valid_o, bus.data_o} !== {1'b0, ev, ed}) begin
        fails++;
        $display("FAIL clamp i=%0d: err=%0b valid=%0b data=%0d, want 0 %0b %0d",
                 i, bus.cfg_err_o, bus.valid_o, bus.data_o, ev, ed);
      end
    end
  endtask
  task automatic test_zero;
    logic [5:0] vv;
    logic [47:0] dv [6];
    logic [47:0] ed;
    vv = 6'b101101;
    dv = '{48'hA1, 48'hB2, 48'hC3, 48'hD4, 48'hE5, 48'hF6};
    drive(1'b0, 48'd0);
    bus.cfg_req_i = 1'b1;
    bus.cfg_depth_i = 6'd0;
    tick;
    tests++;
    if ({bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o, bus.busy_o} !== {1'b1, 1'b0, 1'b0, 48'd51, 1'b1}) begin
      fails++;
      $display("FAIL zero ack: ack=%0b err=%0b valid=%0b data=%0d busy=%0b, want 1 0 0 51 1",
               bus.cfg_ack_o, bus.cfg_err_o, bus.valid_o, bus.data_o, bus.busy_o);
    end
    bus.cfg_req_i = 1'b0;
    ed = 48'd51;
    for (int i = 0; i < 6; i++) begin
      drive(vv[5-i], dv[i]);
      tick;
      if (vv[5-i]) ed = dv[i];
      tests++;
      if ({bus.valid_o, bus.data_o, bus.busy_o} !== {vv[5-i], ed, 1'b0}) begin
        fails++;
        $display("FAIL zero step %0d: valid=%0b data=%0h busy=%0b, want %0b %0h 0",
                 i, bus.valid_o, bus.data_o, bus.busy_o, vv[5-i], ed);
      end
    end
  endtask
  task automatic test_reset_mid;
    logic ev;
    logic [47:0] ed;
    drive(1'b1, 48'h77);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.valid_o, bus.data_o, bus.busy_o, bus.cfg_ack_o} !== {1'b0, 48'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_mid: valid=%0b data=%0h busy=%0b ack=%0b, want 0 0 1 0",
               bus.valid_o, bus.data_o, bus.busy_o, bus.cfg_ack_o);
    end
    tick;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(1'b1, 48'(100 + k));
      tick;
      ev = k == 16;
      ed = k == 16 ? 48'd101 : 48'd0;
      tests++;
      if ({bus.valid_o, bus.data_o} !== {ev, ed}) begin
        fails++;
        $display("FAIL refill k=%0d: valid=%0b data=%0d, want %0b %0d",
                 k, bus.valid_o, bus.data_o, ev, ed);
      end
    end
  endtask
  task automatic test_gap;
    logic [5:0] vv;
    logic [47:0] dv [6];
    logic ev;
    logic [47:0] ed;
    vv = 6'b100111;
    dv = '{48'hAA, 48'h55, 48'h55, 48'hBB, 48'hCC, 48'hDD};
    drive(1'b0, 48'd0);
    bus.cfg_req_i = 1'b1;
    bus.cfg_depth_i = 6'd3;
    tick;
    tests++;
    if ({bus.cfg_ack_o, bus.valid_o, bus.data_o} !== {1'b1, 1'b0, 48'd101}) begin
      fails++;
      $display("FAIL gap ack: ack=%0b valid=%0b data=%0d, want 1 0 101",
               bus.cfg_ack_o, bus.valid_o, bus.data_o);
    end
    bus.cfg_req_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(vv[5-i], dv[i]);
      tick;
      ev = i == 5;
      ed = i == 5 ? 48'hAA : 48'd101;
      tests++;
      if ({bus.valid_o, bus.data_o} !== {ev, ed}) begin
        fails++;
        $display("FAIL gap step %0d: valid=%0b data=%0h, want %0b %0h",
                 i, bus.valid_o, bus.data_o, ev, ed);
      end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ea;
    ea = 4'b1010;
    drive(1'b0, 48'd0);
    bus.cfg_req_i = 1'b1;
    bus.cfg_depth_i = 6'd5;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++;
      if ({bus.cfg_ack_o, bus.cfg_err_o} !== {ea[3-i], 1'b0}) begin
        fails++;
        $display("FAIL rearm step %0d: ack=%0b err=%0b, want %0b 0",
                 i, bus.cfg_ack_o, bus.cfg_err_o, ea[3-i]);
      end
    end
    bus.cfg_req_i = 1'b0;
  endtask
  initial begin
    test_reset;
    test_fill;
    test_depth_change;
    test_clamp;
    test_zero;
    test_reset_mid;
    test_gap;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
